// File: rtl/twiddle_multiply_pkg.sv
// rtl/twiddle_multiply_pkg.sv - Q1.(w-1) fixed-point constants and saturation shared by butterfly stages
package twiddle_multiply_pkg;

  localparam int DEF_LOG_N = 6;
  localparam int DEF_WIDTH = 16;

  function automatic logic signed [63:0] round_half(input int w);
    return 64'sd1 <<< (w - 2);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Clamp a sign-extended value into the w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/cmul_core.sv
// rtl/cmul_core.sv - registered partial products, then round-half-up and saturate (combinational out)
module cmul_core
  import twiddle_multiply_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  output logic        [WIDTH-1:0] re,
  output logic        [WIDTH-1:0] im
);

  localparam logic signed [2*WIDTH:0] ROUND_HALF = (2*WIDTH+1)'(round_half(WIDTH));

  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   sum_re, sum_im, rnd_re, rnd_im, sh_re, sh_im;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      p_rr <= ar * br;
      p_ii <= ai * bi;
      p_ri <= ar * bi;
      p_ir <= ai * br;
    end
  end

  // One guard bit: -1.0 * -1.0 summed twice reaches +2^(2*WIDTH-1).
  always_comb begin
    sum_re = $signed({p_rr[2*WIDTH-1], p_rr}) - $signed({p_ii[2*WIDTH-1], p_ii});
    sum_im = $signed({p_ri[2*WIDTH-1], p_ri}) + $signed({p_ir[2*WIDTH-1], p_ir});
    rnd_re = sum_re + ROUND_HALF;
    rnd_im = sum_im + ROUND_HALF;
    sh_re  = rnd_re >>> (WIDTH - 1);
    sh_im  = rnd_im >>> (WIDTH - 1);
  end

  assign re = WIDTH'(saturate(longint'(sh_re), WIDTH));
  assign im = WIDTH'(saturate(longint'(sh_im), WIDTH));

endmodule

// File: rtl/twiddle_multiply.sv
// rtl/twiddle_multiply.sv - 3-stage complex twiddle multiplier with W^0 bypass and valid pipeline
module twiddle_multiply
  import twiddle_multiply_pkg::*;
#(
  parameter int LOG_N = DEF_LOG_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic [LOG_N-1:0] tw_num,
  input  logic [WIDTH-1:0] tw_re,
  input  logic [WIDTH-1:0] tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  logic             s1_en, s1_z, s2_en, s2_z;
  logic [WIDTH-1:0] s1_dre, s1_dim, s1_twre, s1_twim;
  logic [WIDTH-1:0] s2_dre, s2_dim;
  logic [WIDTH-1:0] core_re, core_im;

  // Idle slots load zeros so undriven inputs never reach the multipliers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_en   <= 1'b0;
      s1_z    <= 1'b0;
      s1_dre  <= '0;
      s1_dim  <= '0;
      s1_twre <= '0;
      s1_twim <= '0;
    end else begin
      s1_en   <= di_en;
      s1_z    <= di_en && (tw_num == '0);
      s1_dre  <= di_en ? di_re : '0;
      s1_dim  <= di_en ? di_im : '0;
      s1_twre <= di_en ? tw_re : '0;
      s1_twim <= di_en ? tw_im : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_en  <= 1'b0;
      s2_z   <= 1'b0;
      s2_dre <= '0;
      s2_dim <= '0;
    end else begin
      s2_en  <= s1_en;
      s2_z   <= s1_z;
      s2_dre <= s1_dre;
      s2_dim <= s1_dim;
    end
  end

  cmul_core #(
    .WIDTH (WIDTH)
  ) u_cmul_core (
    .clock   (clock),
    .reset_n (reset_n),
    .ar      ($signed(s1_dre)),
    .ai      ($signed(s1_dim)),
    .br      ($signed(s1_twre)),
    .bi      ($signed(s1_twim)),
    .re      (core_re),
    .im      (core_im)
  );

  // W^0 = 1 has no Q1 encoding, so that slot takes the delayed input instead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
    end else begin
      do_en <= s2_en;
      if (!s2_en) begin
        do_re <= '0;
        do_im <= '0;
      end else if (s2_z) begin
        do_re <= s2_dre;
        do_im <= s2_dim;
      end else begin
        do_re <= core_re;
        do_im <= core_im;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_multiply.sv
// tb/tb_twiddle_multiply.sv - randomized self-checking bench against a real-arithmetic reference model
module tb_twiddle_multiply;

  localparam int LOG_N = 6;
  localparam int WIDTH = 16;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             di_en   = 1'b0;
  logic [WIDTH-1:0] di_re   = '0;
  logic [WIDTH-1:0] di_im   = '0;
  logic [LOG_N-1:0] tw_num  = '0;
  logic [WIDTH-1:0] tw_re   = '0;
  logic [WIDTH-1:0] tw_im   = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re, do_im;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  bit h_en [3];
  int h_re [3];
  int h_im [3];

  twiddle_multiply #(.LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_num  (tw_num),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  always #5 clock = ~clock;

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Exact in double precision: products stay below 2^31.
  task automatic model(input bit en, input int dre, input int dim, input int num,
                       input int twre, input int twim,
                       output bit oen, output int ore, output int oim);
    real pr, pi;
    if (!en) begin
      oen = 1'b0; ore = 0; oim = 0;
    end else if (num == 0) begin
      oen = 1'b1; ore = dre; oim = dim;
    end else begin
      pr = real'(dre) * real'(twre) - real'(dim) * real'(twim);
      pi = real'(dre) * real'(twim) + real'(dim) * real'(twre);
      oen = 1'b1;
      ore = clamp(int'($floor(pr / 32768.0 + 0.5)));
      oim = clamp(int'($floor(pi / 32768.0 + 0.5)));
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    bit e;
    int r, i;
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        h_en[k] <= 1'b0; h_re[k] <= 0; h_im[k] <= 0;
      end
    end else begin
      model(di_en, int'($signed(di_re)), int'($signed(di_im)), int'(tw_num),
            int'($signed(tw_re)), int'($signed(tw_im)), e, r, i);
      h_en[2] <= h_en[1]; h_re[2] <= h_re[1]; h_im[2] <= h_im[1];
      h_en[1] <= h_en[0]; h_re[1] <= h_re[0]; h_im[1] <= h_im[0];
      h_en[0] <= e;       h_re[0] <= r;       h_im[0] <= i;
    end
  end

  always @(negedge clock) begin
    if (check_on) begin
      checks++;
      if (do_en !== h_en[2] || int'($signed(do_re)) != h_re[2] || int'($signed(do_im)) != h_im[2]
          || $isunknown({do_re, do_im})) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got en=%0b re=%0d im=%0d expected en=%0b re=%0d im=%0d",
                 $time, do_en, $signed(do_re), $signed(do_im), h_en[2], h_re[2], h_im[2]);
      end
    end
  end

  task automatic drive(input bit en, input int dre, input int dim, input int num,
                       input int twre, input int twim);
    @(posedge clock); #1;
    di_en  = en;
    di_re  = WIDTH'(dre);
    di_im  = WIDTH'(dim);
    tw_num = LOG_N'(num);
    tw_re  = WIDTH'(twre);
    tw_im  = WIDTH'(twim);
  endtask

  task automatic check_dut(input string name, input bit een, input int ere, input int eim);
    checks++;
    if (do_en !== een || int'($signed(do_re)) != ere || int'($signed(do_im)) != eim) begin
      errors++;
      $display("FAIL %s got en=%0b re=%0d im=%0d expected en=%0b re=%0d im=%0d",
               name, do_en, $signed(do_re), $signed(do_im), een, ere, eim);
    end
  endtask

  task automatic check_model(input string name, input int dre, input int dim, input int num,
                             input int twre, input int twim, input int ere, input int eim);
    bit e;
    int r, i;
    model(1'b1, dre, dim, num, twre, twim, e, r, i);
    checks++;
    if (r != ere || i != eim) begin
      errors++;
      $display("FAIL %s model got re=%0d im=%0d expected re=%0d im=%0d", name, r, i, ere, eim);
    end
  endtask

  task automatic directed(input string name, input int dre, input int dim, input int num,
                          input int twre, input int twim, input int ere, input int eim);
    drive(1'b1, dre, dim, num, twre, twim);
    drive(1'b0, 0, 0, 0, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0);
    check_dut({name, "_early"}, 1'b0, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0);
    check_dut(name, 1'b1, ere, eim);
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    int pat [5] = '{1, 0, 1, 1, 0};

    check_model("m_quarter", 16384, 0, 16, 0, -32768, 0, -16384);
    check_model("m_sat_im", -32768, -32768, 16, 0, -32768, -32768, 32767);
    check_model("m_round_up", 1, 0, 5, 16384, 0, 1, 0);
    check_model("m_round_neg", -1, 0, 5, 16384, 0, 0, 0);
    check_model("m_bypass", 1234, -567, 0, 0, 0, 1234, -567);
    check_model("m_negate", 1000, 0, 32, -32768, 0, -1000, 0);

    repeat (3) @(posedge clock);
    #1;
    check_dut("reset_state", 1'b0, 0, 0);
    reset_n = 1'b1;
    check_on = 1'b1;

    directed("quarter", 16384, 0, 16, 0, -32768, 0, -16384);
    directed("sat_im", -32768, -32768, 16, 0, -32768, -32768, 32767);
    directed("round_up", 1, 0, 5, 16384, 0, 1, 0);
    directed("round_neg", -1, 0, 5, 16384, 0, 0, 0);
    directed("bypass", 1234, -567, 0, 0, 0, 1234, -567);
    directed("negate", 1000, 0, 32, -32768, 0, -1000, 0);

    // Reset with one sample at the output and three more behind it.
    drive(1'b1, 1000, 0, 32, -32768, 0);
    drive(1'b1, 500, 500, 7, 12000, -9000);
    drive(1'b1, -700, 300, 0, 0, 0);
    drive(1'b1, 42, -42, 9, 30000, 30000);
    check_dut("pre_reset_out", 1'b1, -1000, 0);
    #2;
    reset_n = 1'b0;
    di_en = 1'b0;
    #1;
    check_dut("reset_immediate", 1'b0, 0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    di_en  = 1'b1;
    di_re  = WIDTH'(1000);
    di_im  = '0;
    tw_num = LOG_N'(32);
    tw_re  = WIDTH'(-32768);
    tw_im  = '0;
    drive(1'b0, 0, 0, 0, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0);
    check_dut("post_reset_early", 1'b0, 0, 0);
    drive(1'b0, 0, 0, 0, 0, 0);
    check_dut("post_reset_sample", 1'b1, -1000, 0);

    for (int n = 0; n < 10000; n++) begin
      bit en;
      int num;
      en  = (n < 5) ? pat[n][0] : ($urandom_range(0, 3) != 0);
      num = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
      drive(en, rand_val(), rand_val(), num, rand_val(), rand_val());
    end
    repeat (4) drive(1'b0, 0, 0, 0, 0, 0);
    check_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
